// File: rtl/key_filter_pkg.sv
// Shared types and default timing constants for the pushbutton conditioner.
package key_filter_pkg;

    localparam int unsigned CNT_W = 27;

    // Debounce window minus one: 20 ms at 100 MHz
    localparam logic [CNT_W-1:0] KEY_DEB_20MS = 27'd1_999_999;
    // Long-press threshold minus one: 1 s at 100 MHz
    localparam logic [CNT_W-1:0] KEY_LONG_1S  = 27'd99_999_999;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_e;

endpackage

// File: rtl/key_filter_sync.sv
// Two-flop synchroniser for one asynchronous level.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, both flops load RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronised output (two-cycle delay)
module key_filter_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {2{RST_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/key_filter.sv
// Pushbutton conditioner: synchronise an active-low key, debounce it, and emit
// single-cycle press / release / long-press events plus a debounced level.
//   sys_clk     : system clock, rising edge
//   sys_rst_n   : asynchronous active-low reset
//   key_in_n    : raw key pin, 0 = pressed
//   key_flag    : one-cycle pulse on accepted press
//   key_release : one-cycle pulse on accepted release
//   key_long    : one-cycle pulse once per press after LONG_MAX+1 held cycles
//   key_state   : debounced level, 1 = pressed
module key_filter
    import key_filter_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX  = KEY_DEB_20MS,
    parameter logic [CNT_W-1:0] LONG_MAX = KEY_LONG_1S
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in_n,
    output logic key_flag,
    output logic key_release,
    output logic key_long,
    output logic key_state
);

    logic             w_key_s;
    key_fsm_e         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_long_cnt;
    logic             r_fired;

    // Synchroniser idles at 1 so reset looks like a released key
    key_filter_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     (key_in_n),
        .o_q     (w_key_s)
    );

    // Debounce FSM, counters and registered event outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_long_cnt  <= '0;
            r_fired     <= 1'b0;
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_state   <= 1'b0;
        end else begin
            key_flag    <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_key_s) begin
                        r_state <= PRESS_FILT;
                        r_cnt   <= '0;
                    end
                end

                PRESS_FILT: begin
                    if (w_key_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state    <= HELD;
                        key_flag   <= 1'b1;
                        key_state  <= 1'b1;
                        r_long_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                HELD: begin
                    // Hold counter saturates; the long event fires once on reaching it
                    if (r_long_cnt < LONG_MAX) begin
                        r_long_cnt <= r_long_cnt + CNT_W'(1);
                    end else if (!r_fired) begin
                        key_long <= 1'b1;
                        r_fired  <= 1'b1;
                    end
                    if (w_key_s) begin
                        r_state <= REL_FILT;
                        r_cnt   <= '0;
                    end
                end

                REL_FILT: begin
                    // Hold time is frozen while a release is being qualified
                    if (!w_key_s) begin
                        r_state <= HELD;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state     <= IDLE;
                        key_release <= 1'b1;
                        key_state   <= 1'b0;
                        r_long_cnt  <= '0;
                        r_fired     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_filter.sv
module tb_key_filter;

    localparam int CM = 9;
    localparam int LM = 49;
    localparam int NSEG = 16;

    logic sys_clk;
    logic sys_rst_n;
    logic key_in_n;
    logic key_flag;
    logic key_release;
    logic key_long;
    logic key_state;

    key_filter #(
        .CNT_MAX  (27'd9),
        .LONG_MAX (27'd49)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in_n    (key_in_n),
        .key_flag    (key_flag),
        .key_release (key_release),
        .key_long    (key_long),
        .key_state   (key_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp;
    int n_bad;

    // Reference model: pin delayed two edges, run length of samples that
    // disagree with the debounced level, and a count of held edges per press.
    bit m_s1, m_s2;
    bit m_pressed;
    int m_run;
    int m_held;
    bit e_flag, e_rel, e_long;

    typedef struct {
        bit key;
        int cyc;
        int flags;
        int rels;
        int longs;
        bit st;
        int first_ev;
    } seg_t;

    seg_t tbl [NSEG];

    function automatic void model_reset();
        m_s1      = 1'b1;
        m_s2      = 1'b1;
        m_pressed = 1'b0;
        m_run     = 0;
        m_held    = 0;
        e_flag    = 1'b0;
        e_rel     = 1'b0;
        e_long    = 1'b0;
    endfunction

    function automatic void model_edge(input bit k);
        bit ks;
        bit lvl;
        bit holding;
        ks   = m_s2;
        m_s2 = m_s1;
        m_s1 = k;
        lvl  = ~ks;
        e_flag = 1'b0;
        e_rel  = 1'b0;
        e_long = 1'b0;
        // Held time accrues only while pressed with no release candidate pending
        holding = m_pressed && (m_run == 0);
        if (holding) begin
            if (m_held == LM) e_long = 1'b1;
            m_held++;
        end
        if (lvl != m_pressed) m_run++;
        else                  m_run = 0;
        if (m_run == CM + 2) begin
            m_pressed = lvl;
            m_run     = 0;
            if (lvl) begin
                e_flag = 1'b1;
                m_held = 0;
            end else begin
                e_rel = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_flag"},  int'(key_flag),    int'(e_flag));
        chk({tag, "_rel"},   int'(key_release), int'(e_rel));
        chk({tag, "_long"},  int'(key_long),    int'(e_long));
        chk({tag, "_state"}, int'(key_state),   int'(m_pressed));
    endtask

    task automatic tick(input bit k, output bit f, output bit r, output bit l);
        key_in_n = k;
        @(posedge sys_clk);
        model_edge(k);
        #1;
        chk_outs("cyc");
        f = key_flag;
        r = key_release;
        l = key_long;
    endtask

    task automatic do_reset(input int cycles);
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        chk_outs("rst");
        repeat (cycles) @(posedge sys_clk);
        #1;
        chk_outs("rst_hold");
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit f, r, l;
        int fc, rc, lc, first, lvl_bit, len;

        n_cmp = 0;
        n_bad = 0;

        tbl[0]  = '{1'b1,  5, 0, 0, 0, 1'b0,  0};
        tbl[1]  = '{1'b0, 30, 1, 0, 0, 1'b1, 13};
        tbl[2]  = '{1'b0, 80, 0, 0, 1, 1'b1, 33};
        tbl[3]  = '{1'b1,  5, 0, 0, 0, 1'b1,  0};
        tbl[4]  = '{1'b0, 10, 0, 0, 0, 1'b1,  0};
        tbl[5]  = '{1'b1, 30, 0, 1, 0, 1'b0, 13};
        tbl[6]  = '{1'b0,  3, 0, 0, 0, 1'b0,  0};
        tbl[7]  = '{1'b1,  3, 0, 0, 0, 1'b0,  0};
        tbl[8]  = '{1'b0,  3, 0, 0, 0, 1'b0,  0};
        tbl[9]  = '{1'b1,  3, 0, 0, 0, 1'b0,  0};
        tbl[10] = '{1'b0, 30, 1, 0, 0, 1'b1, 13};
        tbl[11] = '{1'b1, 30, 0, 1, 0, 1'b0, 13};
        tbl[12] = '{1'b0, 45, 1, 0, 0, 1'b1, 13};
        tbl[13] = '{1'b1, 30, 0, 1, 0, 1'b0, 13};
        tbl[14] = '{1'b0, 70, 1, 0, 1, 1'b1, 13};
        tbl[15] = '{1'b1, 30, 0, 1, 0, 1'b0, 13};

        // Power-on reset
        sys_rst_n = 1'b0;
        key_in_n  = 1'b1;
        model_reset();
        #2;
        chk_outs("por");
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Directed segments: event counts, first-event edge and final level
        for (int s = 0; s < NSEG; s++) begin
            fc = 0; rc = 0; lc = 0; first = 0;
            for (int c = 1; c <= tbl[s].cyc; c++) begin
                tick(tbl[s].key, f, r, l);
                if (f) fc++;
                if (r) rc++;
                if (l) lc++;
                if ((f || r || l) && first == 0) first = c;
            end
            chk($sformatf("seg%0d_flags", s), fc, tbl[s].flags);
            chk($sformatf("seg%0d_rels", s),  rc, tbl[s].rels);
            chk($sformatf("seg%0d_longs", s), lc, tbl[s].longs);
            chk($sformatf("seg%0d_state", s), int'(key_state), int'(tbl[s].st));
            if (tbl[s].first_ev != 0)
                chk($sformatf("seg%0d_first_edge", s), first, tbl[s].first_ev);
        end

        // Reset in the middle of the press filter, key kept low
        for (int c = 0; c < 8; c++) tick(1'b0, f, r, l);
        do_reset(2);
        first = 0;
        for (int c = 1; c <= 40 && first == 0; c++) begin
            tick(1'b0, f, r, l);
            if (f) first = c;
        end
        chk("post_rst_flag_edge", first, 13);
        chk("post_rst_state", int'(key_state), 1);

        // Reset in the middle of a hold, then release: no events at all
        for (int c = 0; c < 20; c++) tick(1'b0, f, r, l);
        do_reset(1);
        fc = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, f, r, l);
            if (f || r || l) fc++;
        end
        chk("post_hold_rst_events", fc, 0);

        // Randomised segments against the model, with occasional resets
        lvl_bit = 0;
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 29) == 0) do_reset(int'($urandom_range(1, 3)));
            case ($urandom_range(0, 3))
                0:       len = int'($urandom_range(1, 4));
                1:       len = int'($urandom_range(8, 14));
                2:       len = int'($urandom_range(15, 30));
                default: len = int'($urandom_range(50, 70));
            endcase
            for (int c = 0; c < len; c++) tick(lvl_bit[0], f, r, l);
            lvl_bit = 1 - lvl_bit;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
